// File: rtl/spi_cmd_pkg.sv
// ==== spi_cmd_pkg : shared types and constants for the SPI command front-end ====
// Rev 1.0
`default_nettype none

package spi_cmd_pkg;

  localparam logic [7:0] CMD_DRAW   = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DRAW    = 3'd2,
    WR_SEL  = 3'd3,
    WR_DATA = 3'd4,
    STATUS  = 3'd5,
    IGNORE  = 3'd6
  } spi_state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } draw_rec_t;

  // Occupancy field of the status byte is only five bits wide.
  function automatic logic [4:0] sat_count(input logic [31:0] n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_cmd_fifo.sv
// ==== sprite_cmd_fifo : show-ahead synchronous FIFO of draw records ====
// Rev 1.0
`default_nettype none

module sprite_cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  draw_rec_t                push_data,
  input  logic                     pop,
  output draw_rec_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  draw_rec_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_frontend.sv
// ==== spi_cmd_frontend : oversampled SPI mode-0 slave decoding draw/write/status commands ====
// Rev 1.0
`default_nettype none

module spi_cmd_frontend
  import spi_cmd_pkg::*;
#(
  parameter int SPRITE_NUM   = 16,
  parameter int SPRITE_BYTES = 512,
  parameter int QUEUE_DEPTH  = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             spi_sck,
  input  logic                             spi_cs,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  output logic [$clog2(SPRITE_NUM)-1:0]    w_select,
  output logic                             w_en,
  output logic [$clog2(SPRITE_BYTES)-1:0]  w_addr,
  output logic [7:0]                       w_data,
  input  logic                             dequeue,
  output logic                             is_empty,
  output logic [7:0]                       sprite_id,
  output logic [15:0]                      sprite_x,
  output logic [15:0]                      sprite_y,
  output logic [7:0]                       sprite_scale,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count,
  output logic                             overflow
);

  localparam int SEL_W    = $clog2(SPRITE_NUM);
  localparam int ADDR_W   = $clog2(SPRITE_BYTES);
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   settled;
  spi_state_t             state, state_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_byte;
  logic                   byte_done, ev, sel_ok;
  logic [2:0]             draw_idx;
  logic [39:0]            rec_sr;
  logic                   push;
  draw_rec_t              push_rec, head;
  logic                   fifo_full, fifo_drop;
  logic [ADDR_W-1:0]      addr;
  logic                   wr_full, wr_overrun, wr_overrun_set;
  logic                   status_load;
  logic [7:0]             status_sr;
  logic [3:0]             status_left;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_prev;
  assign sck_fall = !sck_s && sck_prev;
  assign cs_rise  = cs_s && !cs_prev;
  assign cs_fall  = !cs_s && cs_prev;
  // The synchroniser comes out of reset showing cs high; wait until its output
  // and the edge register reflect the pin so an already-low cs is not seen as a fall.
  assign settled  = (settle_cnt == SETTLE_W'(SETTLE));

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync   <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sck_prev   <= 1'b0;
      cs_prev    <= 1'b1;
      settle_cnt <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev   <= sck_s;
      cs_prev    <= cs_s;
      if (!settled) settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_s || state == IDLE) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_byte   <= {rx_byte[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  assign ev             = byte_done && !cs_rise;
  assign sel_ok         = (32'(rx_byte) < SPRITE_NUM);
  assign status_load    = (state == CMD) && ev && (rx_byte == CMD_STATUS);
  assign wr_overrun_set = (state == WR_DATA) && ev && wr_full;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (settled) begin
          if (cs_fall)    state_next = CMD;
          else if (!cs_s) state_next = IGNORE;
        end
      end
      CMD: begin
        if (ev) begin
          case (rx_byte)
            CMD_DRAW:   state_next = DRAW;
            CMD_WRITE:  state_next = WR_SEL;
            CMD_STATUS: state_next = STATUS;
            default:    state_next = IGNORE;
          endcase
        end
      end
      WR_SEL:  if (ev) state_next = sel_ok ? WR_DATA : IGNORE;
      DRAW, WR_DATA, STATUS, IGNORE: state_next = state;
      default: state_next = IDLE;
    endcase
    if (cs_rise) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      draw_idx    <= '0;
      rec_sr      <= '0;
      push        <= 1'b0;
      push_rec    <= '0;
      w_select    <= '0;
      addr        <= '0;
      wr_full     <= 1'b0;
      w_en        <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      wr_overrun  <= 1'b0;
      overflow    <= 1'b0;
      status_sr   <= '0;
      status_left <= '0;
      spi_miso    <= 1'b0;
    end else begin
      push <= 1'b0;
      w_en <= 1'b0;

      if (state != DRAW) begin
        draw_idx <= '0;
      end else if (ev) begin
        rec_sr <= {rec_sr[31:0], rx_byte};
        if (draw_idx == 3'd5) begin
          draw_idx <= '0;
          push     <= 1'b1;
          push_rec <= {rec_sr, rx_byte};
        end else begin
          draw_idx <= draw_idx + 3'd1;
        end
      end

      if (state == WR_SEL && ev && sel_ok) begin
        w_select <= rx_byte[SEL_W-1:0];
        addr     <= '0;
        wr_full  <= 1'b0;
      end
      // The last slot address is written once; later bytes only raise wr_overrun.
      if (state == WR_DATA && ev && !wr_full) begin
        w_en   <= 1'b1;
        w_data <= rx_byte;
        w_addr <= addr;
        if (addr == ADDR_W'(SPRITE_BYTES - 1)) wr_full <= 1'b1;
        else                                   addr    <= addr + ADDR_W'(1);
      end

      if (wr_overrun_set)   wr_overrun <= 1'b1;
      else if (status_load) wr_overrun <= 1'b0;
      if (fifo_drop)        overflow   <= 1'b1;
      else if (status_load) overflow   <= 1'b0;

      if (status_load) begin
        status_sr   <= {overflow, wr_overrun, 1'b0, sat_count(32'(queue_count))};
        status_left <= 4'd8;
      end else if (state == STATUS && sck_fall && status_left != '0) begin
        status_sr   <= {status_sr[6:0], 1'b0};
        status_left <= status_left - 4'd1;
      end

      if (state == STATUS && !cs_s && sck_fall && status_left != '0) spi_miso <= status_sr[7];
      else if (state != STATUS || cs_s || sck_fall)                   spi_miso <= 1'b0;
    end
  end

  assign fifo_drop = push && fifo_full && !(dequeue && !is_empty);

  sprite_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (dequeue),
    .head      (head),
    .full      (fifo_full),
    .empty     (is_empty),
    .count     (queue_count)
  );

  assign sprite_id    = is_empty ? '0 : head.id;
  assign sprite_x     = is_empty ? '0 : head.x;
  assign sprite_y     = is_empty ? '0 : head.y;
  assign sprite_scale = is_empty ? '0 : head.scale;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_frontend.sv
// ==== tb_spi_cmd_frontend : randomized self-checking bench with a queue-based reference model ====
// Rev 1.0
`default_nettype none

module tb_spi_cmd_frontend;

  localparam int SN   = 16;
  localparam int SB   = 512;
  localparam int QD   = 16;
  localparam int SS   = 2;
  localparam int HALF = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0, cs = 1'b1, mosi = 1'b0, dequeue = 1'b0;
  logic        miso, w_en, is_empty, overflow;
  logic [3:0]  w_select;
  logic [8:0]  w_addr;
  logic [7:0]  w_data, sprite_id, sprite_scale;
  logic [15:0] sprite_x, sprite_y;
  logic [4:0]  queue_count;
  logic [47:0] head_w;

  int checks = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  logic        exp_wovr = 1'b0;
  logic [20:0] wq[$];

  always #5 clock = ~clock;

  spi_cmd_frontend #(
    .SPRITE_NUM(SN), .SPRITE_BYTES(SB), .QUEUE_DEPTH(QD), .SYNC_STAGES(SS)
  ) dut (
    .clock(clock), .reset(reset), .spi_sck(sck), .spi_cs(cs), .spi_mosi(mosi),
    .spi_miso(miso), .w_select(w_select), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .dequeue(dequeue), .is_empty(is_empty), .sprite_id(sprite_id), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_scale(sprite_scale), .queue_count(queue_count),
    .overflow(overflow)
  );

  assign head_w = {sprite_id, sprite_x, sprite_y, sprite_scale};

  always @(negedge clock) if (w_en === 1'b1) wq.push_back({w_select, w_addr, w_data});

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus and model helpers (no comparisons) ----------------
  function automatic logic [47:0] rand_rec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  function automatic logic [7:0] exp_status();
    int n;
    n = (exp_q.size() > 31) ? 31 : exp_q.size();
    return {exp_ovf, exp_wovr, 1'b0, 5'(n)};
  endfunction

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(posedge clock);
      #1; rx = {rx[6:0], miso}; sck = 1'b1;
      repeat (HALF) @(posedge clock);
      #1; sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(posedge clock); #1 cs = 1'b0;
    repeat (2 * HALF) @(posedge clock);
  endtask

  task automatic cs_high();
    repeat (HALF) @(posedge clock); #1 cs = 1'b1;
    repeat (16) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] rx;
    spi_xfer(b, rx);
  endtask

  task automatic send_record(input logic [47:0] r);
    for (int b = 5; b >= 0; b--) send_byte(r[b*8 +: 8]);
    if (exp_q.size() < QD) exp_q.push_back(r);
    else                   exp_ovf = 1'b1;
  endtask

  task automatic pop_one();
    logic [47:0] t;
    @(posedge clock); #1 dequeue = 1'b1;
    @(posedge clock); #1 dequeue = 1'b0;
    if (exp_q.size() > 0) t = exp_q.pop_front();
  endtask

  task automatic flush();
    for (int i = 0; i < QD + 2 && is_empty === 1'b0; i++) pop_one();
    exp_q.delete();
  endtask

  task automatic status_read(output logic [7:0] rx);
    cs_low();
    send_byte(8'h03);
    spi_xfer(8'h00, rx);
    cs_high();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clock); #1 reset = 1'b0;
    repeat (10) @(posedge clock); @(negedge clock);
    checks++;
    if (is_empty !== 1'b1) begin failures++; $display("FAIL reset_is_empty got=%b exp=1", is_empty); end
    checks++;
    if ({miso, w_en, w_select, w_addr, w_data, overflow, queue_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got miso=%b w_en=%b sel=%h addr=%h data=%h ovf=%b cnt=%0d exp all 0",
               miso, w_en, w_select, w_addr, w_data, overflow, queue_count);
    end
    checks++;
    if (head_w !== 48'h0) begin failures++; $display("FAIL reset_head got=%h exp=0", head_w); end
  endtask

  task automatic test_draw_basic();
    cs_low(); send_byte(8'h01); send_record(48'h05_0140_00F0_08); cs_high();
    @(negedge clock);
    checks++;
    if (is_empty !== 1'b0) begin failures++; $display("FAIL draw_basic_empty got=%b exp=0", is_empty); end
    checks++;
    if (head_w !== 48'h05_0140_00F0_08) begin failures++; $display("FAIL draw_basic_head got=%h exp=050140 00f008", head_w); end
    checks++;
    if (queue_count !== 5'd1) begin failures++; $display("FAIL draw_basic_count got=%0d exp=1", queue_count); end
    pop_one(); @(negedge clock);
    checks++;
    if (is_empty !== 1'b1 || queue_count !== 5'd0) begin
      failures++; $display("FAIL draw_basic_pop got empty=%b cnt=%0d exp empty=1 cnt=0", is_empty, queue_count);
    end
  endtask

  task automatic test_draw_random();
    int n;
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 3);
      cs_low(); send_byte(8'h01);
      for (int r = 0; r < n; r++) send_record(rand_rec());
      cs_high();
    end
    @(negedge clock);
    checks++;
    if (32'(queue_count) !== exp_q.size()) begin
      failures++; $display("FAIL draw_rand_count got=%0d exp=%0d", queue_count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      @(negedge clock);
      checks++;
      if (head_w !== exp_q[0]) begin failures++; $display("FAIL draw_rand_head got=%h exp=%h", head_w, exp_q[0]); end
      pop_one();
    end
    @(negedge clock);
    checks++;
    if (is_empty !== 1'b1) begin failures++; $display("FAIL draw_rand_drained got=%b exp=1", is_empty); end
  endtask

  task automatic test_write();
    logic [7:0] d [8];
    logic [3:0] sel;
    int n;
    wq.delete();
    cs_low(); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); cs_high();
    checks++;
    if (wq.size() != 3 || wq[0] !== {4'd3, 9'd0, 8'hAA} || wq[1] !== {4'd3, 9'd1, 8'hBB} ||
        wq[2] !== {4'd3, 9'd2, 8'hCC}) begin
      failures++;
      $display("FAIL write_fixed got n=%0d first=%h exp n=3 {3,0..2,AA/BB/CC}", wq.size(),
               (wq.size() > 0) ? wq[0] : 21'h0);
    end
    wq.delete();
    sel = 4'($urandom_range(0, SN - 1));
    n = $urandom_range(1, 8);
    cs_low(); send_byte(8'h02); send_byte({4'h0, sel});
    for (int i = 0; i < n; i++) begin d[i] = 8'($urandom()); send_byte(d[i]); end
    cs_high();
    checks++;
    if (wq.size() != n) begin failures++; $display("FAIL write_rand_len got=%0d exp=%0d", wq.size(), n); end
    for (int i = 0; i < n && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {sel, 9'(i), d[i]}) begin
        failures++; $display("FAIL write_rand_beat got=%h exp=%h", wq[i], {sel, 9'(i), d[i]});
      end
    end
  endtask

  task automatic test_bad_select_and_overrun();
    logic [7:0] d [SB + 1];
    logic [7:0] rx, e;
    logic [3:0] sel;
    int bad;
    wq.delete();
    cs_low(); send_byte(8'h02); send_byte(8'(SN)); send_byte(8'hAA); send_byte(8'hBB); cs_high();
    checks++;
    if (wq.size() != 0) begin failures++; $display("FAIL bad_select got strobes=%0d exp=0", wq.size()); end

    sel = 4'($urandom_range(0, SN - 1));
    cs_low(); send_byte(8'h02); send_byte({4'h0, sel});
    for (int i = 0; i <= SB; i++) begin d[i] = 8'($urandom()); send_byte(d[i]); end
    exp_wovr = 1'b1;
    cs_high();
    checks++;
    if (wq.size() != SB) begin failures++; $display("FAIL overrun_len got=%0d exp=%0d", wq.size(), SB); end
    bad = 0;
    for (int i = 0; i < SB && i < wq.size(); i++) if (wq[i] !== {sel, 9'(i), d[i]}) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL overrun_beats got bad=%0d exp=0", bad); end

    e = exp_status();
    status_read(rx);
    exp_ovf = 1'b0; exp_wovr = 1'b0;
    checks++;
    if (rx !== e) begin failures++; $display("FAIL overrun_status got=%h exp=%h", rx, e); end
    e = exp_status();
    status_read(rx);
    checks++;
    if (rx !== e) begin failures++; $display("FAIL status_cleared got=%h exp=%h", rx, e); end
  endtask

  task automatic test_overflow();
    logic [7:0] rx, e;
    int bad;
    cs_low(); send_byte(8'h01);
    for (int r = 0; r < QD + 1; r++) send_record(rand_rec());
    cs_high();
    @(negedge clock);
    checks++;
    if (32'(queue_count) !== QD) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", queue_count, QD); end
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
    checks++;
    if (head_w !== exp_q[0]) begin failures++; $display("FAIL ovf_head got=%h exp=%h", head_w, exp_q[0]); end
    e = exp_status();
    status_read(rx);
    exp_ovf = 1'b0; exp_wovr = 1'b0;
    checks++;
    if (rx !== e) begin failures++; $display("FAIL ovf_status got=%h exp=%h", rx, e); end
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
    bad = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      if (head_w !== exp_q[0]) bad++;
      pop_one();
    end
    @(negedge clock);
    checks++;
    if (bad != 0 || is_empty !== 1'b1) begin
      failures++; $display("FAIL ovf_drain got bad=%0d empty=%b exp bad=0 empty=1", bad, is_empty);
    end
  endtask

  task automatic test_partial();
    logic [47:0] r;
    cs_low(); send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()));
    cs_high();
    r = rand_rec();
    cs_low(); send_byte(8'h01); send_record(r); cs_high();
    @(negedge clock);
    checks++;
    if (32'(queue_count) !== exp_q.size()) begin
      failures++; $display("FAIL partial_count got=%0d exp=%0d", queue_count, exp_q.size());
    end
    checks++;
    if (head_w !== r) begin failures++; $display("FAIL partial_head got=%h exp=%h", head_w, r); end
    flush();
  endtask

  task automatic test_reset_midburst();
    logic [47:0] r;
    cs_low(); send_byte(8'h01); send_record(rand_rec()); cs_high();
    cs_low(); send_byte(8'h01); send_byte(8'($urandom()));
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock); #1 reset = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; exp_wovr = 1'b0;
    repeat (10) @(posedge clock); @(negedge clock);
    checks++;
    if (is_empty !== 1'b1 || queue_count !== 5'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL midreset_state got empty=%b cnt=%0d ovf=%b exp 1/0/0", is_empty, queue_count, overflow);
    end
    wq.delete();
    send_byte(8'h01);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom()));
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hAA);
    cs_high();
    checks++;
    if (queue_count !== 5'd0 || wq.size() != 0) begin
      failures++; $display("FAIL midreset_ignored got cnt=%0d strobes=%0d exp 0/0", queue_count, wq.size());
    end
    r = rand_rec();
    cs_low(); send_byte(8'h01); send_record(r); cs_high();
    @(negedge clock);
    checks++;
    if (queue_count !== 5'd1 || head_w !== r) begin
      failures++; $display("FAIL midreset_recover got cnt=%0d head=%h exp 1/%h", queue_count, head_w, r);
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_draw_basic();
    test_draw_random();
    test_write();
    test_bad_select_and_overrun();
    test_overflow();
    test_partial();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
